// File: rtl/pcw_download_ctrl_if.sv
// Download-port bundle linking hps_io and boot_loader, pcw_download_ctrl and the pcw_core RAM port.
interface pcw_download_ctrl_if;
  logic        start;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        dn_busy;
  logic        dn_go;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        overflow;

  modport master (
    input  start, rom_data, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr,
           ioctl_data, dn_busy,
    output rom_addr, ioctl_wait, dn_go, dn_wr, dn_addr, dn_data, execute_addr,
           execute_enable, overflow
  );

  modport slave (
    output start, rom_data, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr,
           ioctl_data, dn_busy,
    input  rom_addr, ioctl_wait, dn_go, dn_wr, dn_addr, dn_data, execute_addr,
           execute_enable, overflow
  );
endinterface

// File: rtl/pcw_download_ctrl.sv
// Sole driver of the pcw_core download port: replays the boot ROM into RAM at 0000 on start
// and streams host ioctl images into RAM through a small FIFO, throttling hps_io with ioctl_wait.
module pcw_download_ctrl #(
  parameter logic [15:0] BOOT_ROM_END = 16'd275,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  HOST_INDEX   = 8'd1,
  parameter logic [15:0] HOST_EXEC    = 16'h0000
) (
  input  logic                clk_sys,
  input  logic                reset,
  pcw_download_ctrl_if.master bus
);

  localparam int unsigned      PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned      CntW      = PtrW + 1;
  localparam logic [CntW-1:0]  WaitLevel = CntW'(FIFO_DEPTH - 2);
  localparam logic [CntW-1:0]  FullLevel = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, BOOT_RD, BOOT_WR, HOST, DRAIN, EXEC} state_e;

  state_e          state_q, state_d;
  logic [15:0]     romAddr_q, romAddr_d;
  logic [15:0]     dnAddr_q, dnAddr_d;
  logic [7:0]      dnData_q, dnData_d;
  logic [15:0]     execAddr_q, execAddr_d;
  logic            pendStart_q, pendStart_d;
  logic            overflow_q, overflow_d;
  logic            dnWrLast_q;
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [CntW-1:0] count_q;

  logic [15:0] fifoAddr [FIFO_DEPTH];
  logic [7:0]  fifoData [FIFO_DEPTH];

  logic host, push, accept, pop, bootWr;

  assign host   = bus.ioctl_download && (bus.ioctl_index == HOST_INDEX);
  assign push   = host && bus.ioctl_wr;
  assign accept = push && (count_q != FullLevel);
  // The previous-cycle strobe check keeps host writes at most every other cycle.
  assign pop    = ((state_q == HOST) || (state_q == DRAIN)) && (count_q != '0) &&
                  !bus.dn_busy && !dnWrLast_q;
  assign bootWr = (state_q == BOOT_WR) && !bus.dn_busy;

  always_comb begin
    state_d     = state_q;
    romAddr_d   = romAddr_q;
    dnAddr_d    = dnAddr_q;
    dnData_d    = dnData_q;
    execAddr_d  = execAddr_q;
    pendStart_d = pendStart_q;
    overflow_d  = overflow_q || (push && !accept);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = BOOT_RD;
          romAddr_d = '0;
        end else if (host) begin
          state_d = HOST;
        end
      end
      BOOT_RD: begin
        dnAddr_d = romAddr_q;
        dnData_d = bus.rom_data;
        state_d  = BOOT_WR;
      end
      BOOT_WR: begin
        if (!bus.dn_busy) begin
          if (romAddr_q == BOOT_ROM_END) begin
            state_d    = EXEC;
            execAddr_d = '0;
          end else begin
            romAddr_d = romAddr_q + 16'd1;
            state_d   = BOOT_RD;
          end
        end
      end
      HOST: begin
        if (bus.start) pendStart_d = 1'b1;
        if (!host) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.start) pendStart_d = 1'b1;
        if (count_q == '0) begin
          state_d    = EXEC;
          execAddr_d = HOST_EXEC;
        end
      end
      EXEC: begin
        if (pendStart_q) begin
          state_d     = BOOT_RD;
          romAddr_d   = '0;
          pendStart_d = 1'b0;
        end else if (host && (count_q != '0)) begin
          state_d = HOST;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the popped entry so address/data stay put in the cycle after the strobe.
    if (pop) begin
      dnAddr_d = fifoAddr[rdPtr_q];
      dnData_d = fifoData[rdPtr_q];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      romAddr_q   <= '0;
      dnAddr_q    <= '0;
      dnData_q    <= '0;
      execAddr_q  <= '0;
      pendStart_q <= 1'b0;
      overflow_q  <= 1'b0;
      dnWrLast_q  <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      romAddr_q   <= romAddr_d;
      dnAddr_q    <= dnAddr_d;
      dnData_q    <= dnData_d;
      execAddr_q  <= execAddr_d;
      pendStart_q <= pendStart_d;
      overflow_q  <= overflow_d;
      dnWrLast_q  <= pop || bootWr;
      if (accept) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (pop)    rdPtr_q <= rdPtr_q + PtrW'(1);
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      fifoAddr[wrPtr_q] <= bus.ioctl_addr;
      fifoData[wrPtr_q] <= bus.ioctl_data;
    end
  end

  assign bus.rom_addr       = romAddr_q;
  assign bus.dn_wr          = pop || bootWr;
  assign bus.dn_addr        = pop ? fifoAddr[rdPtr_q] : dnAddr_q;
  assign bus.dn_data        = pop ? fifoData[rdPtr_q] : dnData_q;
  assign bus.dn_go          = (state_q == BOOT_RD) || (state_q == BOOT_WR) ||
                              (state_q == HOST) || (state_q == DRAIN);
  assign bus.execute_enable = (state_q == EXEC);
  assign bus.execute_addr   = execAddr_q;
  assign bus.overflow       = overflow_q;
  assign bus.ioctl_wait     = (count_q >= WaitLevel) || (state_q == BOOT_RD) ||
                              (state_q == BOOT_WR) || (state_q == EXEC);

endmodule

// File: tb/tb_pcw_download_ctrl.sv
// Self-checking bench for pcw_download_ctrl: boot copies, host streaming, overflow, reset abort
// and start-during-host, checked against a queue-based model of the expected RAM writes.
module tb_pcw_download_ctrl;

  localparam logic [15:0] BootEnd  = 16'd275;
  localparam int          BootLen  = 276;
  localparam int          Depth    = 8;
  localparam logic [7:0]  HostIdx  = 8'd1;
  localparam logic [15:0] HostExec = 16'h0100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcw_download_ctrl_if dlIf ();

  pcw_download_ctrl #(
    .BOOT_ROM_END(BootEnd),
    .FIFO_DEPTH  (Depth),
    .HOST_INDEX  (HostIdx),
    .HOST_EXEC   (HostExec)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (dlIf.master)
  );

  logic [7:0] romImg [512];
  always_comb dlIf.rom_data = (dlIf.rom_addr < 16'd512) ? romImg[dlIf.rom_addr[8:0]] : 8'h00;

  int nAsserts = 0;
  int nFails   = 0;

  logic [23:0] wrLog [$];
  logic [23:0] expQ [$];
  logic [15:0] execLog [$];
  int pacingErr = 0, busyErr = 0, holdErr = 0, goErr = 0;
  logic        prevWr = 1'b0;
  logic [23:0] prevEntry = '0;

  // Passive observer of the RAM port and execute pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (dlIf.dn_wr) begin
      wrLog.push_back({dlIf.dn_addr, dlIf.dn_data});
      if (prevWr) pacingErr++;
      if (dlIf.dn_busy) busyErr++;
    end
    if (prevWr && ({dlIf.dn_addr, dlIf.dn_data} !== prevEntry)) holdErr++;
    if (dlIf.execute_enable) begin
      execLog.push_back(dlIf.execute_addr);
      if (dlIf.dn_go) goErr++;
    end
    prevWr    = dlIf.dn_wr;
    prevEntry = {dlIf.dn_addr, dlIf.dn_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    wrLog.delete();
    expQ.delete();
    execLog.delete();
    pacingErr = 0; busyErr = 0; holdErr = 0; goErr = 0;
  endtask

  // Boot image: either the addr^5A pattern or random bytes; expected writes are addr 0..BootEnd.
  task automatic loadBootImage(input bit pattern);
    for (int a = 0; a < BootLen; a++) begin
      romImg[a] = pattern ? (8'(a) ^ 8'h5A) : 8'($urandom);
      expQ.push_back({16'(a), romImg[a]});
    end
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, "_count"}, 32'(wrLog.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < wrLog.size(); i++)
      checkOutput($sformatf("%s_wr%0d", tag, i), 32'(wrLog[i]), 32'(expQ[i]));
    checkOutput({tag, "_pacing"}, 32'(pacingErr), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busyErr), 32'd0);
    checkOutput({tag, "_hold"}, 32'(holdErr), 32'd0);
    checkOutput({tag, "_go_at_exec"}, 32'(goErr), 32'd0);
  endtask

  task automatic waitExec(input int n, input int budget, input string tag);
    int cyc = 0;
    while (execLog.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    checkOutput(tag, 32'(execLog.size()), 32'(n));
  endtask

  task automatic pulseStart();
    dlIf.start = 1'b1;
    tick();
    dlIf.start = 1'b0;
  endtask

  // Host image honouring ioctl_wait with random dn_busy; optional start pulse after startAfter bytes.
  task automatic applyStimulus(input logic [15:0] base, input int nBytes, input int startAfter,
                               output bit sawWait);
    int sent = 0;
    int occ;
    bit started = 1'b0;
    int writes0 = wrLog.size();
    sawWait = 1'b0;
    dlIf.ioctl_download = 1'b1;
    dlIf.ioctl_index    = HostIdx;
    for (int cyc = 0; cyc < 4000 && sent < nBytes; cyc++) begin
      dlIf.dn_busy = 1'($urandom_range(0, 1));
      if (!started && startAfter >= 0 && sent == startAfter) begin
        dlIf.start = 1'b1;
        started    = 1'b1;
      end
      if (!dlIf.ioctl_wait) begin
        dlIf.ioctl_wr   = 1'b1;
        dlIf.ioctl_addr = base + 16'(sent);
        dlIf.ioctl_data = 8'($urandom);
        expQ.push_back({dlIf.ioctl_addr, dlIf.ioctl_data});
        sent++;
      end else begin
        dlIf.ioctl_wr = 1'b0;
      end
      tick();
      dlIf.start = 1'b0;
      occ = sent - (wrLog.size() - writes0);
      checkOutput("host_wait", 32'(dlIf.ioctl_wait), 32'(occ >= Depth - 2));
      if (occ == Depth - 2 && dlIf.ioctl_wait) sawWait = 1'b1;
    end
    dlIf.ioctl_wr = 1'b0;
    checkOutput("host_sent", 32'(sent), 32'(nBytes));
    for (int cyc = 0; cyc < 4000 && (wrLog.size() - writes0) < nBytes; cyc++) begin
      dlIf.dn_busy = 1'($urandom_range(0, 1));
      tick();
    end
    dlIf.dn_busy        = 1'b0;
    dlIf.ioctl_download = 1'b0;
  endtask

  initial begin
    int  n;
    bit  sawWait;

    reset               = 1'b1;
    dlIf.start          = 1'b0;
    dlIf.ioctl_download = 1'b0;
    dlIf.ioctl_index    = 8'h00;
    dlIf.ioctl_wr       = 1'b0;
    dlIf.ioctl_addr     = '0;
    dlIf.ioctl_data     = '0;
    dlIf.dn_busy        = 1'b0;
    for (int a = 0; a < 512; a++) romImg[a] = 8'h00;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_dn_go", 32'(dlIf.dn_go), 32'd0);
    checkOutput("rst_dn_wr", 32'(dlIf.dn_wr), 32'd0);
    checkOutput("rst_exec_en", 32'(dlIf.execute_enable), 32'd0);
    checkOutput("rst_exec_addr", 32'(dlIf.execute_addr), 32'd0);
    checkOutput("rst_wait", 32'(dlIf.ioctl_wait), 32'd0);
    checkOutput("rst_overflow", 32'(dlIf.overflow), 32'd0);
    checkOutput("rst_dn_addr", 32'(dlIf.dn_addr), 32'd0);
    checkOutput("rst_rom_addr", 32'(dlIf.rom_addr), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] boot copy with addr^5A pattern");
    clearLogs();
    loadBootImage(1'b1);
    pulseStart();
    n = 1;
    checkOutput("boot_go_first", 32'(dlIf.dn_go), 32'd1);
    checkOutput("boot_wait", 32'(dlIf.ioctl_wait), 32'd1);
    checkOutput("boot_rom_addr0", 32'(dlIf.rom_addr), 32'd0);
    while (!dlIf.execute_enable && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("boot_exec_cycle", 32'(n), 32'd553);
    checkOutput("boot_exec_addr", 32'(dlIf.execute_addr), 32'h0000);
    checkOutput("boot_exec_go", 32'(dlIf.dn_go), 32'd0);
    tick();
    checkOutput("boot_exec_once", 32'(dlIf.execute_enable), 32'd0);
    checkOutput("boot_idle_go", 32'(dlIf.dn_go), 32'd0);
    repeat (4) tick();
    checkOutput("boot_exec_count", 32'(execLog.size()), 32'd1);
    compareLog("boot1");

    $display("[TB] boot copy with dn_busy at byte 10");
    clearLogs();
    loadBootImage(1'b0);
    pulseStart();
    for (int c = 0; c < 200 && dlIf.rom_addr != 16'd10; c++) tick();
    checkOutput("busy_reach_10", 32'(dlIf.rom_addr), 32'd10);
    tick();
    dlIf.dn_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("busy_no_strobe", 32'(dlIf.dn_wr), 32'd0);
      tick();
    end
    checkOutput("busy_rom_hold", 32'(dlIf.rom_addr), 32'd10);
    dlIf.dn_busy = 1'b0;
    waitExec(1, 2000, "busy_exec");
    checkOutput("busy_exec_addr", 32'(execLog[0]), 32'h0000);
    repeat (3) tick();
    compareLog("boot2");

    $display("[TB] host image of 32 bytes at 4000");
    clearLogs();
    applyStimulus(16'h4000, 32, -1, sawWait);
    checkOutput("host_saw_wait6", 32'(sawWait), 32'd1);
    waitExec(1, 100, "host_exec");
    checkOutput("host_exec_addr", 32'(execLog[0]), 32'(HostExec));
    repeat (4) tick();
    checkOutput("host_exec_count", 32'(execLog.size()), 32'd1);
    checkOutput("host_overflow", 32'(dlIf.overflow), 32'd0);
    compareLog("host");

    $display("[TB] host ignoring ioctl_wait with dn_busy held");
    clearLogs();
    dlIf.dn_busy        = 1'b1;
    dlIf.ioctl_download = 1'b1;
    dlIf.ioctl_index    = HostIdx;
    for (int i = 0; i < 12; i++) begin
      dlIf.ioctl_wr   = 1'b1;
      dlIf.ioctl_addr = 16'h6000 + 16'(i);
      dlIf.ioctl_data = 8'($urandom);
      if (i < Depth) expQ.push_back({dlIf.ioctl_addr, dlIf.ioctl_data});
      tick();
    end
    dlIf.ioctl_wr = 1'b0;
    checkOutput("ovf_flag", 32'(dlIf.overflow), 32'd1);
    checkOutput("ovf_wait", 32'(dlIf.ioctl_wait), 32'd1);
    checkOutput("ovf_no_writes", 32'(wrLog.size()), 32'd0);
    dlIf.dn_busy = 1'b0;
    for (int c = 0; c < 100 && wrLog.size() < Depth; c++) tick();
    dlIf.ioctl_download = 1'b0;
    waitExec(1, 100, "ovf_exec");
    repeat (3) tick();
    checkOutput("ovf_sticky", 32'(dlIf.overflow), 32'd1);
    compareLog("ovf");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("ovf_cleared", 32'(dlIf.overflow), 32'd0);
    tick();

    $display("[TB] reset during boot byte 100");
    clearLogs();
    loadBootImage(1'b0);
    pulseStart();
    for (int c = 0; c < 400 && dlIf.rom_addr != 16'd100; c++) tick();
    checkOutput("abort_reach_100", 32'(dlIf.rom_addr), 32'd100);
    reset = 1'b1;
    tick();
    checkOutput("abort_dn_wr", 32'(dlIf.dn_wr), 32'd0);
    checkOutput("abort_dn_go", 32'(dlIf.dn_go), 32'd0);
    checkOutput("abort_exec_en", 32'(dlIf.execute_enable), 32'd0);
    reset = 1'b0;
    repeat (10) tick();
    checkOutput("abort_no_exec", 32'(execLog.size()), 32'd0);
    checkOutput("abort_quiet", 32'(wrLog.size()), 32'd100);
    clearLogs();
    loadBootImage(1'b0);
    pulseStart();
    waitExec(1, 2000, "reboot_exec");
    repeat (3) tick();
    compareLog("reboot");

    $display("[TB] start pulse in the middle of a host image");
    clearLogs();
    applyStimulus(16'h5000, 16, 8, sawWait);
    loadBootImage(1'b0);
    waitExec(2, 3000, "mixed_exec");
    repeat (4) tick();
    checkOutput("mixed_exec_count", 32'(execLog.size()), 32'd2);
    checkOutput("mixed_exec0_addr", 32'(execLog[0]), 32'(HostExec));
    checkOutput("mixed_exec1_addr", 32'(execLog[1]), 32'h0000);
    checkOutput("mixed_idle_go", 32'(dlIf.dn_go), 32'd0);
    compareLog("mixed");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
